header_block_packer: RTL and testbench
======================================

Name: header_block_packer

Overview:
Writer-side counterpart of messageSplit. Accepts the 640-bit block header as a stream of 32-bit words over a valid/ready handshake and assembles them in order. It appends SHA-256 padding and the length field, then presents the finished 1024-bit message block to the hashing datapath. The block is held until the consumer acknowledges it, then the packer accepts the next header.

Parameters:
WORD_W, 32, width of each input word in bits
HDR_WORDS, 20, words per header (header length = WORD_W*HDR_WORDS = 640 bits)
BLOCK_W, 1024, output block width; must satisfy WORD_W*HDR_WORDS + 65 <= BLOCK_W

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_word  input  WORD_W  header word; first word is most significant
in_valid  input  1  in_word is valid this cycle
in_last  input  1  marks the final header word; qualified by in_valid
in_ready  output  1  packer can accept a word this cycle
block_out  output  BLOCK_W  padded message block
block_valid  output  1  block_out is complete and stable
block_ack  input  1  consumer has taken block_out; qualified by block_valid
word_count  output  5  words accepted into the current header (0..HDR_WORDS)
err  output  1  one-cycle pulse on a framing error

Behaviour:
- Reset (asynchronous assert, released synchronously to clk) clears everything:
  - state=COLLECT, word_count=0, header register=0, block_out=0, block_valid=0, err=0.
  - in_ready=0 while rst is high; in_ready=1 from the first clock edge after release.
- States: COLLECT, FULL.
- COLLECT:
  - in_ready=1.
  - A word is accepted when in_valid&&in_ready at a rising edge.
  - Word k (0-based) is written to header bits [BLOCK_W-1-WORD_W*k -: WORD_W].
  - word_count increments on each accepted word.
- Normal completion: word k=HDR_WORDS-1 accepted with in_last=1.
  - Next cycle: state=FULL, block_valid=1, word_count=HDR_WORDS.
  - block_out = {header, 1'b1, zeros, 64-bit length}; the length field equals WORD_W*HDR_WORDS (0x280 at defaults).
  - At defaults: header in [1023:384], bit 383=1, [382:64]=0, [63:0]=0x280.
- Latency: one cycle from the final accepted word to block_valid. Minimum throughput is HDR_WORDS+1 cycles per block.
- FULL:
  - in_ready=0; incoming in_valid is ignored and no data is lost.
  - block_out and block_valid are held stable until block_ack is sampled high.
  - On block_ack: next cycle block_valid=0, word_count=0, header register cleared, state=COLLECT, in_ready=1.
  - block_out keeps its last value after ack (it is not cleared).
- Early last: in_last=1 on word k<HDR_WORDS-1.
  - The word is accepted, err pulses for one cycle, and the partial header is discarded.
  - word_count=0 next cycle; state stays COLLECT; no block is emitted.
- Missing last: word HDR_WORDS-1 accepted with in_last=0.
  - The block is still emitted normally, and err pulses in the same cycle block_valid first rises.
- block_ack while block_valid=0 is ignored.
- A rising rst during COLLECT or FULL aborts immediately:
  - partial header lost, block_valid drops asynchronously, no err pulse.
- word_count never exceeds HDR_WORDS and has no wrap-around.

Test Plan:
1. Reset then stream words 0x00000001..0x00000014 back-to-back, in_last on the 20th -> block_valid one cycle after the last word. block_out[1023:992]=0x00000001, [415:384]=0x00000014, [383:352]=0x80000000, [63:0]=0x0000000000000280, all other padding bits 0.
2. Stream the 20 words of header 0x01000000_50120119_..._00000000, hold block_ack=0 for 10 cycles -> block_out stable and in_ready=0 throughout; extra in_valid words are not absorbed. Ack -> block_valid=0 and in_ready=1 next cycle.
3. Random in_valid gaps (50% duty) and block_ack in the same cycle as first re-entry -> block_out equal to the gap-free run; word_count sequence 0..20 then 0.
4. in_last on word 5 -> err single-cycle pulse, word_count=0, no block_valid. A following clean 20-word header -> correct block, no err.
5. 20 words with in_last=0 -> block emitted, err=1 exactly in the cycle block_valid rises.
6. Assert rst after 12 words -> block_valid=0, in_ready=0, word_count=0 immediately. After release, a full header packs correctly with no residue from the aborted header.

Source files
------------

// File: rtl/header_block_packer.sv
// Collects a block header as a stream of words, then emits one SHA-256 padded
// message block and holds it until the consumer acknowledges it.
module header_block_packer #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned HDR_WORDS = 20,
    parameter int unsigned BLOCK_W   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WORD_W-1:0]  in_word,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [BLOCK_W-1:0] block_out,
    output logic               block_valid,
    input  logic               block_ack,
    output logic [4:0]         word_count,
    output logic               err
);

    localparam int unsigned CNT_W  = 5;
    localparam int unsigned HDR_W  = WORD_W * HDR_WORDS;
    localparam int unsigned TAIL_W = BLOCK_W - HDR_W;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(HDR_WORDS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(HDR_WORDS);

    // Padding tail: the single '1' marker, zero fill, and the 64-bit bit-length.
    localparam logic [TAIL_W-1:0] TAIL = (TAIL_W'(1) << (TAIL_W - 1)) | TAIL_W'(HDR_W);

    typedef enum logic {
        COLLECT,
        FULL
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [HDR_W-1:0]   hdr_q, hdr_d;
    logic [HDR_W-1:0]   hdr_ins;
    logic [BLOCK_W-1:0] blk_q, blk_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic               accept;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            hdr_q   <= '0;
            blk_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            blk_q   <= blk_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        blk_d   = blk_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        hdr_ins = hdr_q;
        accept  = in_valid && ready_q;

        // Header with the incoming word dropped into its slot, first word at the MSBs
        for (int unsigned i = 0; i < HDR_WORDS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                hdr_ins[HDR_W-1-WORD_W*i -: WORD_W] = in_word;
            end
        end

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (cnt_q == LAST_IDX) begin
                        hdr_d   = hdr_ins;
                        blk_d   = {hdr_ins, TAIL};
                        valid_d = 1'b1;
                        cnt_d   = FULL_CNT;
                        err_d   = !in_last;
                        state_d = FULL;
                    end else if (in_last) begin
                        // Truncated header: drop it and resynchronise on the next word
                        hdr_d = '0;
                        cnt_d = '0;
                        err_d = 1'b1;
                    end else begin
                        hdr_d = hdr_ins;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FULL: begin
                if (block_ack) begin
                    valid_d = 1'b0;
                    hdr_d   = '0;
                    cnt_d   = '0;
                    state_d = COLLECT;
                end
            end
        endcase

        ready_d = (state_d == COLLECT);
    end

    assign in_ready    = ready_q;
    assign block_out   = blk_q;
    assign block_valid = valid_q;
    assign word_count  = cnt_q;
    assign err         = err_q;

endmodule

// File: tb/tb_header_block_packer.sv
// Randomised self-checking bench for header_block_packer against a queue-based
// reference model of header assembly and padding.
module tb_header_block_packer;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned HDR_WORDS = 20;
    localparam int unsigned BLOCK_W   = 1024;

    logic               clk = 1'b0;
    logic               rst;
    logic [WORD_W-1:0]  in_word;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic [BLOCK_W-1:0] block_out;
    logic               block_valid;
    logic               block_ack;
    logic [4:0]         word_count;
    logic               err;

    header_block_packer #(
        .WORD_W   (WORD_W),
        .HDR_WORDS(HDR_WORDS),
        .BLOCK_W  (BLOCK_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_word    (in_word),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .block_out  (block_out),
        .block_valid(block_valid),
        .block_ack  (block_ack),
        .word_count (word_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: words of the header in progress, plus expected outputs
    logic [WORD_W-1:0]  mq[$];
    logic [BLOCK_W-1:0] exp_blk;
    bit                 exp_valid;
    int                 exp_cnt;
    logic [WORD_W-1:0]  hdr[HDR_WORDS];
    logic [BLOCK_W-1:0] saved_blk;

    task automatic check(input string tag, input logic [BLOCK_W-1:0] obs, input logic [BLOCK_W-1:0] exp);
        logic [BLOCK_W-1:0] diff;
        int d;
        int base;
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            diff = obs ^ exp;
            d = 0;
            for (int i = 0; i < BLOCK_W; i++) begin
                if (diff[i] !== 1'b0) begin
                    d = i;
                    break;
                end
            end
            base = (d / 128) * 128;
            $display("FAIL %s: got %h expected %h (bits %0d+:128)", tag, obs[base +: 128], exp[base +: 128], base);
        end
    endtask

    function automatic logic [BLOCK_W-1:0] build_block(input logic [WORD_W-1:0] q[$]);
        logic [BLOCK_W-1:0] b;
        b = '0;
        for (int i = 0; i < q.size(); i++) b[BLOCK_W-1-WORD_W*i -: WORD_W] = q[i];
        b[BLOCK_W-1-WORD_W*HDR_WORDS] = 1'b1;
        b[63:0] = 64'(WORD_W * HDR_WORDS);
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cnt"}, BLOCK_W'(word_count), BLOCK_W'(exp_cnt));
        check({tag, "_valid"}, BLOCK_W'(block_valid), BLOCK_W'(exp_valid));
        check({tag, "_err"}, BLOCK_W'(err), '0);
    endtask

    // Offer one word, optionally after random idle cycles, and check the outcome
    task automatic push_word(input logic [WORD_W-1:0] w, input bit last, input bit gaps);
        bit exp_err;
        while (gaps && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            tick();
            check_idle("gap");
        end
        check("rdy_before_word", BLOCK_W'(in_ready), BLOCK_W'(1));
        in_valid = 1'b1;
        in_word  = w;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        mq.push_back(w);
        if (mq.size() == HDR_WORDS) begin
            exp_blk   = build_block(mq);
            exp_valid = 1'b1;
            exp_err   = !last;
            exp_cnt   = HDR_WORDS;
            mq.delete();
        end else if (last) begin
            exp_err = 1'b1;
            exp_cnt = 0;
            mq.delete();
        end else begin
            exp_err = 1'b0;
            exp_cnt = mq.size();
        end
        check("word_cnt", BLOCK_W'(word_count), BLOCK_W'(exp_cnt));
        check("word_valid", BLOCK_W'(block_valid), BLOCK_W'(exp_valid));
        check("word_err", BLOCK_W'(err), BLOCK_W'(exp_err));
        if (exp_valid) begin
            check("block", block_out, exp_blk);
            check("rdy_full", BLOCK_W'(in_ready), '0);
        end
    endtask

    // Sends hdr[]; last_idx marks the word carrying in_last (>= HDR_WORDS for none)
    task automatic send_header(input int last_idx, input bit gaps);
        for (int i = 0; i < HDR_WORDS; i++) begin
            push_word(hdr[i], i == last_idx, gaps);
            if (i == last_idx && i < HDR_WORDS - 1) break;
        end
    endtask

    // Holds the block for n cycles (optionally offering junk words), then acks it
    task automatic hold_and_ack(input int n, input bit junk, input bit reentry);
        for (int i = 0; i < n; i++) begin
            in_valid = junk;
            in_word  = $urandom;
            tick();
            check("hold_valid", BLOCK_W'(block_valid), BLOCK_W'(1));
            check("hold_rdy", BLOCK_W'(in_ready), '0);
            check("hold_cnt", BLOCK_W'(word_count), BLOCK_W'(HDR_WORDS));
            check("hold_block", block_out, exp_blk);
        end
        in_valid  = reentry;
        in_word   = hdr[0];
        block_ack = 1'b1;
        tick();
        block_ack = 1'b0;
        in_valid  = 1'b0;
        exp_valid = 1'b0;
        exp_cnt   = 0;
        check("ack_valid", BLOCK_W'(block_valid), '0);
        check("ack_rdy", BLOCK_W'(in_ready), BLOCK_W'(1));
        check("ack_cnt", BLOCK_W'(word_count), '0);
        check("ack_block_kept", block_out, exp_blk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        mq.delete();
        exp_cnt   = 0;
        exp_valid = 1'b0;
        exp_blk   = '0;
        check("rst_valid", BLOCK_W'(block_valid), '0);
        check("rst_rdy", BLOCK_W'(in_ready), '0);
        check("rst_cnt", BLOCK_W'(word_count), '0);
        check("rst_err", BLOCK_W'(err), '0);
        check("rst_block", block_out, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rel_rdy_low", BLOCK_W'(in_ready), '0);
        tick();
        check("rel_rdy_high", BLOCK_W'(in_ready), BLOCK_W'(1));
    endtask

    initial begin
        rst       = 1'b1;
        in_word   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        block_ack = 1'b0;
        exp_blk   = '0;
        exp_valid = 1'b0;
        exp_cnt   = 0;

        // 1: counting header, back-to-back
        apply_reset();
        for (int i = 0; i < HDR_WORDS; i++) hdr[i] = 32'(i + 1);
        send_header(HDR_WORDS - 1, 1'b0);
        check("t1_w0", BLOCK_W'(block_out[1023:992]), BLOCK_W'(32'h0000_0001));
        check("t1_w19", BLOCK_W'(block_out[415:384]), BLOCK_W'(32'h0000_0014));
        check("t1_pad", BLOCK_W'(block_out[383:352]), BLOCK_W'(32'h8000_0000));
        check("t1_len", BLOCK_W'(block_out[63:0]), BLOCK_W'(64'h280));
        check("t1_zero", BLOCK_W'(block_out[351:64]), '0);
        saved_blk = exp_blk;
        hold_and_ack(2, 1'b0, 1'b0);

        // 2: long hold with junk words offered
        hdr[0] = 32'h0100_0000;
        hdr[1] = 32'h5012_0119;
        for (int i = 2; i < HDR_WORDS - 1; i++) hdr[i] = $urandom;
        hdr[HDR_WORDS-1] = 32'h0000_0000;
        send_header(HDR_WORDS - 1, 1'b0);
        hold_and_ack(10, 1'b1, 1'b0);

        // 3: counting header again with gaps; ack coincides with next first word
        for (int i = 0; i < HDR_WORDS; i++) hdr[i] = 32'(i + 1);
        send_header(HDR_WORDS - 1, 1'b1);
        check("t3_same", block_out, saved_blk);
        hold_and_ack(1, 1'b0, 1'b1);

        // 4: early last on word 5 (ack while idle must be harmless), then clean header
        for (int i = 0; i < HDR_WORDS; i++) hdr[i] = $urandom;
        block_ack = 1'b1;
        send_header(5, 1'b0);
        block_ack = 1'b0;
        tick();
        check_idle("t4_after");
        send_header(HDR_WORDS - 1, 1'b0);
        hold_and_ack(1, 1'b0, 1'b0);

        // 5: missing last
        for (int i = 0; i < HDR_WORDS; i++) hdr[i] = $urandom;
        send_header(HDR_WORDS, 1'b1);
        hold_and_ack(1, 1'b0, 1'b0);

        // 6: reset mid-header, then reset while a block is held
        for (int i = 0; i < HDR_WORDS; i++) hdr[i] = $urandom;
        for (int i = 0; i < 12; i++) push_word(hdr[i], 1'b0, 1'b0);
        apply_reset();
        for (int i = 0; i < HDR_WORDS; i++) hdr[i] = $urandom;
        send_header(HDR_WORDS - 1, 1'b0);
        hold_and_ack(1, 1'b0, 1'b0);
        send_header(HDR_WORDS - 1, 1'b1);
        apply_reset();

        // Random mix of framings and gaps
        for (int t = 0; t < 6; t++) begin
            int mode;
            int li;
            for (int i = 0; i < HDR_WORDS; i++) hdr[i] = $urandom;
            mode = $urandom_range(0, 2);
            li = (mode == 0) ? HDR_WORDS - 1 : (mode == 1) ? HDR_WORDS : $urandom_range(0, HDR_WORDS - 2);
            send_header(li, 1'b1);
            if (exp_valid) hold_and_ack($urandom_range(0, 3), 1'b1, 1'b0);
            else begin
                tick();
                check_idle("rnd_idle");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute run-time guard
    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
